freelist_ctrl: RTL and testbench

Bitmap free-list controller that owns the release side of rename and reservation-station allocation. Each cycle it presents one registered, pre-selected free entry to the consumer. It accepts one entry release per cycle and supports a wholesale bitmap restore for misprediction recovery. The allocation pick uses the tree priority rule of the existing priority selector: the highest-index free entry wins.

---
 rtl/freelist_ctrl.sv | 175 +++++++++++++++++
 tb/tb_freelist_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/freelist_ctrl.sv
// -----------------------------------------------------------------------------
// freelist_ctrl
// Bitmap free-list controller for rename / reservation-station allocation.
// Each cycle one registered, pre-selected free entry (highest free index) is
// presented to the consumer. The controller accepts one release per cycle and
// can have its whole free bitmap replaced for misprediction recovery.
//
// Optional feature macro: FREELIST_DBLFREE_CHECK_EN
//   defined   -> err_double_free pulses for one cycle after each double free
//   undefined -> err_double_free is tied low and the detect logic is removed
// -----------------------------------------------------------------------------

`ifndef N_PHYS_REG
`define N_PHYS_REG 64
`endif

module freelist_ctrl #(
   parameter int N_ENTRIES  = `N_PHYS_REG,
   parameter int N_RESERVED = 32,
   parameter int IDX_W      = $clog2(N_ENTRIES)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 alloc_req,
   output logic                 alloc_avail,
   output logic [IDX_W-1:0]     alloc_idx,
   input  logic                 free_valid,
   input  logic [IDX_W-1:0]     free_idx,
   input  logic                 restore_valid,
   input  logic [N_ENTRIES-1:0] restore_map,
   output logic [IDX_W:0]       free_count,
   output logic                 err_double_free
);

   localparam int CNT_W = IDX_W + 1;

   // Entries at or above N_RESERVED start out free; the rest hold the
   // architectural mapping.
   function automatic logic [N_ENTRIES-1:0] build_reset_map();
      logic [N_ENTRIES-1:0] m;
      m = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         m[i] = (i >= N_RESERVED);
      end
      return m;
   endfunction

   localparam logic [N_ENTRIES-1:0] RESET_MAP   = build_reset_map();
   localparam logic                 RESET_AVAIL = (N_RESERVED < N_ENTRIES);
   localparam logic [IDX_W-1:0]     RESET_IDX   = RESET_AVAIL ? IDX_W'(N_ENTRIES - 1) : '0;
   localparam logic [CNT_W-1:0]     RESET_CNT   = CNT_W'(N_ENTRIES - N_RESERVED);

   // Priority selector (enable tied high): a request wins when no request at a
   // higher index is present, so the result is one-hot on the highest set bit.
   function automatic logic [N_ENTRIES-1:0] pick_highest(input logic [N_ENTRIES-1:0] req);
      logic [N_ENTRIES-1:0] above;
      above[N_ENTRIES-1] = 1'b0;
      for (int i = N_ENTRIES - 2; i >= 0; i--) begin
         above[i] = above[i+1] | req[i+1];
      end
      return req & ~above;
   endfunction

   // One-hot to binary index; an all-zero grant encodes to index 0.
   function automatic logic [IDX_W-1:0] encode_onehot(input logic [N_ENTRIES-1:0] grant);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (grant[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
      return idx;
   endfunction

   // Population count, used only when a restore replaces the whole bitmap.
   function automatic logic [CNT_W-1:0] popcount(input logic [N_ENTRIES-1:0] m);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         c = c + CNT_W'(m[i]);
      end
      return c;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [N_ENTRIES-1:0] fb_q, fb_d;
   logic                 alloc_avail_q, alloc_avail_d;
   logic [IDX_W-1:0]     alloc_idx_q, alloc_idx_d;
   logic [CNT_W-1:0]     free_count_q, free_count_d;

   logic                 take;
   logic                 free_accept;
   logic [N_ENTRIES-1:0] grant;

   // Next bitmap, count and pre-selected entry, with restore taking priority
   // over the take/free pair.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is
      // inferred on paths that do not assign it.
      take         = alloc_req & alloc_avail_q;
      free_accept  = free_valid & ~fb_q[free_idx];
      fb_d         = fb_q;
      free_count_d = free_count_q;

      if (restore_valid) begin
         fb_d         = restore_map;
         free_count_d = popcount(restore_map);
      end else begin
         // A take always hits a set bit and an accepted free always hits a
         // clear bit of fb_q, so the two can never target the same entry.
         if (take) begin
            fb_d[alloc_idx_q] = 1'b0;
         end
         if (free_accept) begin
            fb_d[free_idx] = 1'b1;
         end
         free_count_d = free_count_q + CNT_W'(free_accept) - CNT_W'(take);
      end

      grant         = pick_highest(fb_d);
      alloc_avail_d = |fb_d;
      alloc_idx_d   = encode_onehot(grant);
   end

   // Bitmap, presented entry and count registers with synchronous reset.
   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!reset) begin
         fb_q          <= RESET_MAP;
         alloc_avail_q <= RESET_AVAIL;
         alloc_idx_q   <= RESET_IDX;
         free_count_q  <= RESET_CNT;
      end else begin
         fb_q          <= fb_d;
         alloc_avail_q <= alloc_avail_d;
         alloc_idx_q   <= alloc_idx_d;
         free_count_q  <= free_count_d;
      end
   end

   assign alloc_avail = alloc_avail_q;
   assign alloc_idx   = alloc_idx_q;
   assign free_count  = free_count_q;

   // ---------------------------------------------------------------------------
   // Double-free detection
   // ---------------------------------------------------------------------------
`ifdef FREELIST_DBLFREE_CHECK_EN
   logic err_q, err_d;

   // A release of an entry that is already free in the current bitmap is a
   // double free; restore cycles discard the release and never flag.
   always_comb begin
      err_d = free_valid & fb_q[free_idx] & ~restore_valid;
   end

   // One-cycle error pulse register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_double_free = err_q;
`else
   assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freelist_ctrl
// Directed bench for freelist_ctrl with N_ENTRIES=8, N_RESERVED=4. A set-based
// model of the free list is compared against the DUT on every cycle, and the
// scenarios also carry hand-computed literal expectations.
// Honours FREELIST_DBLFREE_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_freelist_ctrl;
   localparam int N = 8;
   localparam int R = 4;
   localparam int W = 3;

`ifdef FREELIST_DBLFREE_CHECK_EN
   localparam logic EXP_DBL = 1'b1;
`else
   localparam logic EXP_DBL = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         alloc_req = 1'b0;
   logic         free_valid = 1'b0;
   logic [W-1:0] free_idx = '0;
   logic         restore_valid = 1'b0;
   logic [N-1:0] restore_map = '0;
   logic         alloc_avail;
   logic [W-1:0] alloc_idx;
   logic [W:0]   free_count;
   logic         err_double_free;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Model state: the set of free entries and the expected error flag.
   logic [N-1:0] m_free;
   logic         m_err;

   always #5 clock = ~clock;

   freelist_ctrl #(.N_ENTRIES(N), .N_RESERVED(R)) dut (
      .clock          (clock),
      .reset          (reset),
      .alloc_req      (alloc_req),
      .alloc_avail    (alloc_avail),
      .alloc_idx      (alloc_idx),
      .free_valid     (free_valid),
      .free_idx       (free_idx),
      .restore_valid  (restore_valid),
      .restore_map    (restore_map),
      .free_count     (free_count),
      .err_double_free(err_double_free)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Highest free entry of a set (0 when empty).
   function automatic int m_top(input logic [N-1:0] f);
      int r = 0;
      for (int i = 0; i < N; i++) if (f[i]) r = i;
      return r;
   endfunction

   function automatic int m_cnt(input logic [N-1:0] f);
      int c = 0;
      for (int i = 0; i < N; i++) if (f[i]) c++;
      return c;
   endfunction

   // Model update: what the free set becomes after this edge.
   always @(posedge clock) begin : model
      logic [N-1:0] nxt;
      bit           tk;
      bit           dbl;
      if (!reset) begin
         m_free <= 8'hF0;
         m_err  <= 1'b0;
      end else if (restore_valid) begin
         m_free <= restore_map;
         m_err  <= 1'b0;
      end else begin
         nxt = m_free;
         tk  = alloc_req && (m_free != '0);
         dbl = free_valid && m_free[free_idx];
         if (tk) nxt[m_top(m_free)] = 1'b0;
         if (free_valid && !dbl) nxt[free_idx] = 1'b1;
         m_free <= nxt;
         m_err  <= dbl && EXP_DBL;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         check("cyc_avail", 32'(alloc_avail), 32'(m_free != '0));
         check("cyc_idx", 32'(alloc_idx), (m_free != '0) ? m_top(m_free) : 0);
         check("cyc_count", 32'(free_count), m_cnt(m_free));
         check("cyc_err", 32'(err_double_free), 32'(m_err));
      end
   end

   // Drive one cycle of inputs, then return at the following falling edge.
   task automatic cyc(input bit rq, input bit fv, input int fi, input bit rv, input logic [N-1:0] rm);
      alloc_req     = rq;
      free_valid    = fv;
      free_idx      = W'(fi);
      restore_valid = rv;
      restore_map   = rm;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic expect_out(input string tag, input bit av, input int idx, input int cnt, input bit err);
      check({tag, "_avail"}, 32'(alloc_avail), 32'(av));
      check({tag, "_idx"}, 32'(alloc_idx), idx);
      check({tag, "_count"}, 32'(free_count), cnt);
      check({tag, "_err"}, 32'(err_double_free), 32'(err));
   endtask

   initial begin : stim
      int d_idx[5] = '{6, 5, 4, 0, 0};
      int d_cnt[5] = '{3, 2, 1, 0, 0};
      bit d_av[5]  = '{1, 1, 1, 0, 0};

      // Reset held across two edges, with traffic that must be ignored.
      reset = 1'b0;
      @(negedge clock);
      cyc(1, 1, 0, 0, '0);
      chk_en = 1'b1;
      cyc(0, 0, 0, 0, '0);
      expect_out("reset", 1, 7, 4, 0);
      reset = 1'b1;

      // Drain: 7 is presented, then 6,5,4; fifth request is a no-op.
      for (int k = 0; k < 5; k++) begin
         cyc(1, 0, 0, 0, '0);
         expect_out($sformatf("drain%0d", k), d_av[k], d_idx[k], d_cnt[k], 0);
      end

      // Refill from empty.
      cyc(0, 1, 5, 0, '0);
      expect_out("refill", 1, 5, 1, 0);

      // Take 5 while freeing 2.
      cyc(1, 1, 2, 0, '0);
      expect_out("simul", 1, 2, 1, 0);

      // Double free of 2, then the pulse must drop.
      cyc(0, 1, 2, 0, '0);
      expect_out("dblfree", 1, 2, 1, EXP_DBL);
      cyc(0, 0, 0, 0, '0);
      expect_out("dbl_drop", 1, 2, 1, 0);

      // Restore beats a take and a free of 1; then drain the restored map.
      cyc(1, 1, 1, 1, 8'b1010_0000);
      expect_out("restore", 1, 7, 2, 0);
      cyc(1, 0, 0, 0, '0);
      expect_out("rest_take1", 1, 5, 1, 0);
      cyc(1, 0, 0, 0, '0);
      expect_out("rest_take2", 0, 0, 0, 0);

      // A double free under restore is discarded and never flagged.
      cyc(0, 1, 3, 0, '0);
      expect_out("free3", 1, 3, 1, 0);
      cyc(0, 1, 3, 1, 8'b0000_1000);
      expect_out("rest_dbl", 1, 3, 1, 0);

      // Reset wins over a simultaneous restore, take and free.
      reset = 1'b0;
      cyc(1, 1, 0, 1, 8'hFF);
      expect_out("rst_restore", 1, 7, 4, 0);
      reset = 1'b1;

      // Freeing the entry being taken is a double free; the take proceeds.
      cyc(1, 1, 7, 0, '0);
      expect_out("take_dbl", 1, 6, 3, EXP_DBL);

      // Freeing a reserved-range entry is legal.
      cyc(0, 1, 0, 0, '0);
      expect_out("free_rsv", 1, 6, 4, 0);

      // Mixed deterministic traffic, checked by the per-cycle model compare.
      for (int i = 0; i < 40; i++) begin
         cyc((i % 3) != 0, (i % 2) == 1, (i * 5) % N, i == 23, 8'b0101_0011);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
